// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for ram_port_arbiter: flat per-requester request
// and response vectors. Requesters drive through master; the arbiter uses slave.
interface ram_port_arbiter_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 3,
  parameter int unsigned NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_we;
  logic [NUM_REQ*ADDRWIDTH-1:0] req_addr;
  logic [NUM_REQ*DATAWIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ*DATAWIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a 2-write/2-read flip-flop RAM among NUM_REQ requesters,
// with registered RAM commands and tagged read-data return.
module ram_port_arbiter #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 3,
  parameter int unsigned NUM_REQ   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    req,
  output logic                 en_w1_n,
  output logic                 en_w2_n,
  output logic [ADDRWIDTH-1:0] addr_w1,
  output logic [ADDRWIDTH-1:0] addr_w2,
  output logic [DATAWIDTH-1:0] data_w1,
  output logic [DATAWIDTH-1:0] data_w2,
  output logic                 en_r1_n,
  output logic                 en_r2_n,
  output logic [ADDRWIDTH-1:0] addr_r1,
  output logic [ADDRWIDTH-1:0] addr_r2,
  input  logic [DATAWIDTH-1:0] data_r1,
  input  logic [DATAWIDTH-1:0] data_r2
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  typedef logic [IdxW-1:0] idx_t;

  idx_t wr_ptr, rd_ptr, r1_tag, r2_tag;
  idx_t w1_idx, w2_idx, r1_idx, r2_idx, wj, rj;
  logic w1_hit, w2_hit, r1_hit, r2_hit;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ*DATAWIDTH-1:0] rsp_data_q;
  logic [ADDRWIDTH-1:0] addr_a [NUM_REQ];
  logic [DATAWIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req.req_addr[g*ADDRWIDTH +: ADDRWIDTH];
    assign wdata_a[g] = req.req_wdata[g*DATAWIDTH +: DATAWIDTH];
  end

  // Both operands are below NUM_REQ, so a single conditional subtract wraps correctly.
  function automatic idx_t wrap_add(idx_t base, int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  always_comb begin
    wr_gnt = '0;
    w1_hit = 1'b0;
    w2_hit = 1'b0;
    w1_idx = '0;
    w2_idx = '0;
    wj     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      wj = wrap_add(wr_ptr, k);
      if (req.req_valid[wj] && req.req_we[wj]) begin
        if (!w1_hit) begin
          w1_hit     = 1'b1;
          w1_idx     = wj;
          wr_gnt[wj] = 1'b1;
        end else if (!w2_hit && (addr_a[wj] != addr_a[w1_idx])) begin
          // Same-address writes are deferred so the two RAM write ports never collide.
          w2_hit     = 1'b1;
          w2_idx     = wj;
          wr_gnt[wj] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_gnt = '0;
    r1_hit = 1'b0;
    r2_hit = 1'b0;
    r1_idx = '0;
    r2_idx = '0;
    rj     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rj = wrap_add(rd_ptr, k);
      if (req.req_valid[rj] && !req.req_we[rj]) begin
        if (!r1_hit) begin
          r1_hit     = 1'b1;
          r1_idx     = rj;
          rd_gnt[rj] = 1'b1;
        end else if (!r2_hit) begin
          r2_hit     = 1'b1;
          r2_idx     = rj;
          rd_gnt[rj] = 1'b1;
        end
      end
    end
  end

  assign req.req_ready = rst ? '0 : (wr_gnt | rd_gnt);
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_data  = rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_w1_n     <= 1'b1;
      en_w2_n     <= 1'b1;
      en_r1_n     <= 1'b1;
      en_r2_n     <= 1'b1;
      addr_w1     <= '0;
      addr_w2     <= '0;
      addr_r1     <= '0;
      addr_r2     <= '0;
      data_w1     <= '0;
      data_w2     <= '0;
      r1_tag      <= '0;
      r2_tag      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      en_w1_n <= ~w1_hit;
      en_w2_n <= ~w2_hit;
      en_r1_n <= ~r1_hit;
      en_r2_n <= ~r2_hit;
      addr_w1 <= addr_a[w1_idx];
      addr_w2 <= addr_a[w2_idx];
      data_w1 <= wdata_a[w1_idx];
      data_w2 <= wdata_a[w2_idx];
      addr_r1 <= addr_a[r1_idx];
      addr_r2 <= addr_a[r2_idx];
      r1_tag  <= r1_idx;
      r2_tag  <= r2_idx;
      if (w1_hit) wr_ptr <= wrap_add(w2_hit ? w2_idx : w1_idx, 1);
      if (r1_hit) rd_ptr <= wrap_add(r2_hit ? r2_idx : r1_idx, 1);

      // RAM read data is valid while the registered read enable is low.
      rsp_valid_q <= '0;
      if (!en_r1_n) begin
        rsp_valid_q[r1_tag]                         <= 1'b1;
        rsp_data_q[r1_tag*DATAWIDTH +: DATAWIDTH] <= data_r1;
      end
      if (!en_r2_n) begin
        rsp_valid_q[r2_tag]                         <= 1'b1;
        rsp_data_q[r2_tag*DATAWIDTH +: DATAWIDTH] <= data_r2;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural flip-flop RAM attached.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_w1_n, en_w2_n, en_r1_n, en_r2_n;
  logic [2:0] addr_w1, addr_w2, addr_r1, addr_r2;
  logic [7:0] data_w1, data_w2, data_r1, data_r2;
  logic [7:0] mem [8];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATAWIDTH(8), .ADDRWIDTH(3), .NUM_REQ(4)) bus ();

  ram_port_arbiter #(.DATAWIDTH(8), .ADDRWIDTH(3), .NUM_REQ(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .en_w1_n (en_w1_n),
    .en_w2_n (en_w2_n),
    .addr_w1 (addr_w1),
    .addr_w2 (addr_w2),
    .data_w1 (data_w1),
    .data_w2 (data_w2),
    .en_r1_n (en_r1_n),
    .en_r2_n (en_r2_n),
    .addr_r1 (addr_r1),
    .addr_r2 (addr_r2),
    .data_r1 (data_r1),
    .data_r2 (data_r2)
  );

  always @(posedge clk) begin
    if (!en_w1_n) mem[addr_w1] <= data_w1;
    if (!en_w2_n) mem[addr_w2] <= data_w2;
  end
  assign data_r1 = mem[addr_r1];
  assign data_r2 = mem[addr_r2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic we, input logic [2:0] a, input logic [7:0] d);
    bus.req_valid[i]         = 1'b1;
    bus.req_we[i]            = we;
    bus.req_addr[i*3 +: 3]   = a;
    bus.req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic drop(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 3'(i), 8'(8'h10 + i));

    // Reset with all requesters active
    tick(); tick(); tick();
    check("rst_ready", bus.req_ready, 4'b0000);
    check("rst_en", {en_w1_n, en_w2_n, en_r1_n, en_r2_n}, 4'hF);
    check("rst_rsp", bus.rsp_valid, 4'b0000);

    // Round-robin writes: {0,1}, {2,3}, {0,1}
    rst = 1'b0;
    #1;
    check("rr_ready_a", bus.req_ready, 4'b0011);
    tick();
    check("rr_ready_b", bus.req_ready, 4'b1100);
    check("rr_en_a", {en_w1_n, en_w2_n, en_r1_n, en_r2_n}, 4'b0011);
    check("rr_addr_a", {addr_w1, addr_w2}, {3'd0, 3'd1});
    tick();
    check("rr_ready_c", bus.req_ready, 4'b0011);
    check("rr_addr_b", {addr_w1, addr_w2}, {3'd2, 3'd3});
    check("rr_data_b", {data_w1, data_w2}, 16'h1213);
    tick();
    bus.req_valid = '0;

    // Single write then read of addr 3 (wr_ptr is 2 here)
    drive(0, 1'b1, 3'd3, 8'hA5);
    #1;
    check("sw_ready", bus.req_ready, 4'b0001);
    tick();
    check("sw_en", {en_w1_n, en_w2_n}, 2'b01);
    check("sw_cmd", {addr_w1, data_w1}, {3'd3, 8'hA5});
    drive(0, 1'b0, 3'd3, 8'h00);
    #1;
    check("sr_ready", bus.req_ready, 4'b0001);
    tick();
    drop(0);
    check("sr_cmd", {en_r1_n, en_r2_n, addr_r1}, {2'b01, 3'd3});
    tick();
    check("sr_rsp_valid", bus.rsp_valid, 4'b0001);
    check("sr_rsp_data", bus.rsp_data[7:0], 8'hA5);
    tick();
    check("sr_rsp_pulse", bus.rsp_valid, 4'b0000);

    // Write collision on addr 5 with wr_ptr=1
    drive(1, 1'b1, 3'd5, 8'h11);
    drive(2, 1'b1, 3'd5, 8'h22);
    #1;
    check("col_ready_a", bus.req_ready, 4'b0010);
    tick();
    drop(1);
    check("col_cmd_a", {en_w1_n, en_w2_n, addr_w1, data_w1}, {2'b01, 3'd5, 8'h11});
    #1;
    check("col_ready_b", bus.req_ready, 4'b0100);
    tick();
    drop(2);
    check("col_cmd_b", {en_w1_n, en_w2_n, addr_w1, data_w1}, {2'b01, 3'd5, 8'h22});
    drive(3, 1'b0, 3'd5, 8'h00);
    #1;
    check("col_rd_ready", bus.req_ready, 4'b1000);
    tick();
    drop(3);
    tick();
    check("col_rd_valid", bus.rsp_valid, 4'b1000);
    check("col_rd_data", bus.rsp_data[31:24], 8'h22);

    // Mixed traffic: writes from 0,2 and reads from 1,3
    drive(0, 1'b1, 3'd1, 8'h5A);
    drive(2, 1'b1, 3'd2, 8'hC3);
    drive(1, 1'b0, 3'd3, 8'h00);
    drive(3, 1'b0, 3'd5, 8'h00);
    #1;
    check("mix_ready", bus.req_ready, 4'b1111);
    tick();
    bus.req_valid = '0;
    check("mix_en", {en_w1_n, en_w2_n, en_r1_n, en_r2_n}, 4'b0000);
    check("mix_waddr", {addr_w1, addr_w2, data_w1, data_w2}, {3'd1, 3'd2, 8'h5A, 8'hC3});
    check("mix_raddr", {addr_r1, addr_r2}, {3'd3, 3'd5});
    tick();
    check("mix_rsp_valid", bus.rsp_valid, 4'b1010);
    check("mix_rsp_data", {bus.rsp_data[15:8], bus.rsp_data[31:24]}, 16'hA522);

    // Same-cycle RAW on addr 6: preload 0x0F, then write 0xF0 while reading
    drive(0, 1'b1, 3'd6, 8'h0F);
    tick();
    drive(0, 1'b1, 3'd6, 8'hF0);
    drive(1, 1'b0, 3'd6, 8'h00);
    #1;
    check("raw_ready", bus.req_ready, 4'b0011);
    tick();
    bus.req_valid = '0;
    tick();
    check("raw_rsp_valid", bus.rsp_valid, 4'b0010);
    check("raw_rsp_data", bus.rsp_data[15:8], 8'h0F);
    drive(2, 1'b0, 3'd6, 8'h00);
    #1;
    check("raw2_ready", bus.req_ready, 4'b0100);
    tick();
    drop(2);
    tick();
    check("raw2_rsp_data", bus.rsp_data[23:16], 8'hF0);
    check("raw_hold", bus.rsp_data[15:8], 8'h0F);

    // Reset while a read is in flight discards its response
    drive(0, 1'b0, 3'd3, 8'h00);
    #1;
    check("mid_ready", bus.req_ready, 4'b0001);
    tick();
    drop(0);
    check("mid_cmd", en_r1_n, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rsp", bus.rsp_valid, 4'b0000);
    check("mid_en", {en_w1_n, en_w2_n, en_r1_n, en_r2_n}, 4'hF);
    rst = 1'b0;
    tick();
    check("mid_rsp_after", bus.rsp_valid, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the dual-write/dual-read flip-flop RAM (DATAWIDTH x 2^ADDRWIDTH) among NUM_REQ requesters. Each cycle it accepts up to two writes and two reads with round-robin fairness and resolves same-address write collisions. It drives the RAM's active-low port enables from registers and returns read data to the originating requester. It sits between the requester clients and the RAM instance.

Parameters:
DATAWIDTH, 8, RAM word width
ADDRWIDTH, 3, RAM address width (2^ADDRWIDTH words)
NUM_REQ, 4, number of requesters (2..8)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request present, one bit per requester
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDRWIDTH  flat address, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
req_wdata  in  NUM_REQ*DATAWIDTH  flat write data
req_ready  out  NUM_REQ  combinational grant; transfer when valid&ready
rsp_valid  out  NUM_REQ  registered read-response strobe
rsp_data  out  NUM_REQ*DATAWIDTH  registered read data, held until next response to that requester
en_w1_n, en_w2_n  out  1 each  RAM write enables, active low
addr_w1, addr_w2  out  ADDRWIDTH  RAM write addresses
data_w1, data_w2  out  DATAWIDTH  RAM write data
en_r1_n, en_r2_n  out  1 each  RAM read enables, active low
addr_r1, addr_r2  out  ADDRWIDTH  RAM read addresses
data_r1, data_r2  in  DATAWIDTH  RAM read data, valid in the cycle en_rX_n is low (combinational FF-array read)

Behaviour:
- Reset (rst=1 at edge): en_*_n=1, addr_*/data_w*=0, rsp_valid=0, rsp_data=0, wr_ptr=0, rd_ptr=0, internal read tags cleared. req_ready forced 0 while rst=1.
- One request per requester per cycle; req_we selects type. Requests not granted must be held by the requester (valid/addr/data stable until ready).
- Write grant, cycle T: scan i = wr_ptr, wr_ptr+1, ... mod NUM_REQ over valid&we. First hit -> slot W1. Next hit whose address differs from W1 -> slot W2. Same-address hits are skipped (deferred), and the scan continues. At most 2 write grants.
- Read grant, cycle T: same scan from rd_ptr over valid&~we -> slots R1, R2. No address restriction; two reads to the same address are both granted.
- Pointer update at edge T: wr_ptr <= (last granted write index + 1) mod NUM_REQ. rd_ptr is updated the same way for reads. A pointer is unchanged when it had no grants that cycle.
- Pipeline:
  - T: req_ready asserted.
  - T+1: registered RAM command. en_*_n=0 on used slots, 1 on unused; read tag holds the requester index.
  - Edge ending T+1: RAM write commits; data_r1/data_r2 captured into rsp_data of the tagged requester, with rsp_valid pulsed for one cycle (T+2).
- Read latency: accept at T -> rsp_valid at T+2. Fully pipelined; a new grant is possible every cycle.
- Read and write to the same address driven in the same cycle: the read returns pre-write contents. There is no forwarding.
- A write accepted at T is visible to a read accepted at T+1 or later.
- R1 and R2 never target the same requester in one cycle, because a requester issues only one request per cycle.
- Reset mid-operation: in-flight RAM commands and pending responses are discarded with no rsp_valid. RAM contents are not affected by this block.
- NUM_REQ not a power of two: pointer wraps explicitly at NUM_REQ-1 -> 0.

Test Plan:
- Reset: hold rst 3 cycles with all req_valid=1 -> req_ready=0, en_w1_n=en_w2_n=en_r1_n=en_r2_n=1, rsp_valid=0. Release -> first grant on the next cycle.
- Single write then read: req0 writes addr 3 data 0xA5 at T. At T+1, en_w1_n=0, addr_w1=3, data_w1=0xA5. req0 reads addr 3 at T+1 -> rsp_valid[0]=1, rsp_data=0xA5 at T+3.
- Round-robin writes: all 4 requesters write distinct addresses every cycle, wr_ptr=0 -> grants {0,1}, then {2,3}, then {0,1}. No requester waits more than 2 cycles.
- Write collision: req1 and req2 both write addr 5 (0x11, 0x22), wr_ptr=1 -> req1 granted and req2 deferred. The next cycle req2 is granted. A final read of addr 5 returns 0x22.
- Mixed traffic: req0 and req2 write, req1 and req3 read, same cycle -> all four ready. Both write slots and both read slots are enabled at T+1. rsp_valid[1] and rsp_valid[3] pulse at T+2 with the correct data.
- Same-cycle RAW: addr 6 holds 0x0F. req0 writes 0xF0 to addr 6 while req1 reads addr 6 in the same cycle -> rsp_data for req1 = 0x0F. A subsequent read returns 0xF0.
